// File: rtl/x25519_mult_arbiter.sv
// Round-robin share of one non-pipelined X25519 field multiplier between NUM_REQ requesters,
// with registered operands, result routing and a sticky watchdog on a hung multiplier.
module x25519_mult_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 264,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     mult_en,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic                     mult_out_valid,
  input  logic [WIDTH-1:0]         mult_out,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [PW-1:0]  LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);

  // state  | meaning
  // S_IDLE | no job; sample req_valid and grant round-robin
  // S_WAIT | operands held at multiplier; watchdog running
  // S_ERR  | watchdog fired; frozen until reset
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
  logic [WIDTH-1:0]     mult_a_q, mult_a_d;
  logic [WIDTH-1:0]     mult_b_q, mult_b_d;
  logic                 mult_en_q, mult_en_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_out_q, rsp_out_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 found;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        scan_idx;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] k);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (k == PW'(c)) v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] k);
    return (k == LAST_IDX) ? '0 : k + 1'b1;
  endfunction

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first set request wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (gnt_idx == PW'(c)) begin
        sel_a = req_a[c*WIDTH +: WIDTH];
        sel_b = req_b[c*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    wd_cnt_d      = wd_cnt_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    mult_en_d     = 1'b0;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_out_d     = rsp_out_q;
    rsp_err_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = gnt_idx;
          mult_a_d    = sel_a;
          mult_b_d    = sel_b;
          mult_en_d   = 1'b1;
          req_ready_d = onehot(gnt_idx);
          wd_cnt_d    = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // A result arriving on the limit cycle still counts as a normal completion.
        if (mult_out_valid) begin
          rsp_out_d   = mult_out;
          rsp_valid_d = onehot(grant_q);
          rr_ptr_d    = next_idx(grant_q);
          state_d     = S_IDLE;
        end else if (wd_cnt_q == WD_LIMIT) begin
          rsp_out_d     = '0;
          rsp_valid_d   = onehot(grant_q);
          rsp_err_d     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_ERR;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      wd_cnt_q      <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      mult_en_q     <= 1'b0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_out_q     <= '0;
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      wd_cnt_q      <= wd_cnt_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      mult_en_q     <= mult_en_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_out_q     <= rsp_out_d;
      rsp_err_q     <= rsp_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mult_en     = mult_en_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_out     = rsp_out_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule
